// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost movement stage.
// Directions are one-hot; state encoding is shared with the bench.
package ghost_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_CAUGHT = 2'd2
  } ghost_state_t;

  function automatic int tile_log2(input int tile);
    return $clog2(tile);
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] lowest_bit4(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/ghost_mover_if.sv
// Bundle between chase logic, pacman state and the ghost mover.
// master drives requests and pacman position; slave is the mover.
interface ghost_mover_if;

  logic        move_tick;
  logic        enable;
  logic        respawn;
  logic [3:0]  valid_moves;
  logic [3:0]  ctrl_dir;
  logic [10:0] pacman_pos_x;
  logic [9:0]  pacman_pos_y;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  ghost_dir;
  logic        caught;
  logic        moving;

  modport master (
    output move_tick,
    output enable,
    output respawn,
    output valid_moves,
    output ctrl_dir,
    output pacman_pos_x,
    output pacman_pos_y,
    input  ghost_pos_x,
    input  ghost_pos_y,
    input  ghost_dir,
    input  caught,
    input  moving
  );

  modport slave (
    input  move_tick,
    input  enable,
    input  respawn,
    input  valid_moves,
    input  ctrl_dir,
    input  pacman_pos_x,
    input  pacman_pos_y,
    output ghost_pos_x,
    output ghost_pos_y,
    output ghost_dir,
    output caught,
    output moving
  );

endinterface

// File: rtl/ghost_collision_check.sv
// Per-axis absolute-difference proximity test between ghost and pacman.
// Both axes are widened to 12 bits unsigned so no signed wrap occurs.
module ghost_collision_check
  import ghost_pkg::*;
#(
  parameter int DIST = 8
) (
  input  logic [10:0] i_ax,
  input  logic [9:0]  i_ay,
  input  logic [10:0] i_bx,
  input  logic [9:0]  i_by,
  output logic        o_hit
);

  logic [11:0] w_ax;
  logic [11:0] w_ay;
  logic [11:0] w_bx;
  logic [11:0] w_by;
  logic [11:0] w_dx;
  logic [11:0] w_dy;

  assign w_ax = {1'b0, i_ax};
  assign w_bx = {1'b0, i_bx};
  assign w_ay = {2'b00, i_ay};
  assign w_by = {2'b00, i_by};

  assign w_dx = (w_ax >= w_bx) ? (w_ax - w_bx)
                               : (w_bx - w_ax);
  assign w_dy = (w_ay >= w_by) ? (w_ay - w_by)
                               : (w_by - w_ay);

  assign o_hit = (w_dx < 12'(DIST))
              && (w_dy < 12'(DIST));

endmodule

// File: rtl/ghost_mover.sv
// One ghost's position/heading registers, house release delay
// and capture FSM, stepped once per frame tick.
module ghost_mover
  import ghost_pkg::*;
#(
  parameter logic [10:0] START_X       = 11'd320,
  parameter logic [9:0]  START_Y       = 10'd240,
  parameter logic [3:0]  START_DIR     = DIR_LEFT,
  parameter int          STEP          = 2,
  parameter int          TILE          = 16,
  parameter int          RELEASE_TICKS = 60,
  parameter int          SCREEN_W      = 640,
  parameter int          COLLIDE_DIST  = 8
) (
  input logic        clk,
  input logic        rst_n,
  ghost_mover_if.slave bus
);

  localparam int TL    = tile_log2(TILE);
  localparam int CNT_W = $clog2(RELEASE_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RELEASE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [10:0] STEP_X = 11'(STEP);
  localparam logic [9:0]  STEP_Y = 10'(STEP);
  localparam logic [10:0] X_LAST = 11'(SCREEN_W - STEP);

  ghost_state_t     r_state;
  logic [10:0]      r_x;
  logic [9:0]       r_y;
  logic [3:0]       r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_caught;
  logic             r_moving;

  logic        w_hit;
  logic        w_aligned;
  logic        w_sel_ctrl;
  logic        w_sel_keep;
  logic        w_sel_low;
  logic        w_go;
  logic [3:0]  w_dir;
  logic [10:0] w_x;
  logic [9:0]  w_y;

  ghost_collision_check #(
    .DIST(COLLIDE_DIST)
  ) u_hit (
    .i_ax (r_x),
    .i_ay (r_y),
    .i_bx (bus.pacman_pos_x),
    .i_by (bus.pacman_pos_y),
    .o_hit(w_hit)
  );

  assign w_aligned = (r_x[TL-1:0] == '0)
                  && (r_y[TL-1:0] == '0);

  // Selects are made exclusive so the decoder below is truly unique.
  assign w_sel_ctrl = is_onehot4(bus.ctrl_dir)
    && |(bus.ctrl_dir & bus.valid_moves);
  assign w_sel_keep = !w_sel_ctrl
    && |(r_dir & bus.valid_moves);
  assign w_sel_low  = !w_sel_ctrl && !w_sel_keep
    && |bus.valid_moves;

  always_comb begin
    w_dir = r_dir;
    w_go  = 1'b1;
    if (w_aligned) begin
      unique case (1'b1)
        w_sel_ctrl: w_dir = bus.ctrl_dir;
        w_sel_keep: w_dir = r_dir;
        w_sel_low:  w_dir = lowest_bit4(bus.valid_moves);
        default:    w_go  = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_x = r_x;
    w_y = r_y;
    unique case (1'b1)
      w_dir[0]: w_x = (r_x >= X_LAST) ? '0 : r_x + STEP_X;
      w_dir[1]: w_y = r_y - STEP_Y;
      w_dir[2]: w_y = r_y + STEP_Y;
      w_dir[3]: w_x = (r_x == '0) ? X_LAST : r_x - STEP_X;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT;
      r_x      <= START_X;
      r_y      <= START_Y;
      r_dir    <= START_DIR;
      r_cnt    <= '0;
      r_caught <= 1'b0;
      r_moving <= 1'b0;
    end else if (!bus.enable) begin
      r_caught <= 1'b0;
    end else if (bus.respawn) begin
      r_state  <= ST_WAIT;
      r_x      <= START_X;
      r_y      <= START_Y;
      r_dir    <= START_DIR;
      r_cnt    <= '0;
      r_caught <= 1'b0;
      r_moving <= 1'b0;
    end else begin
      r_caught <= 1'b0;
      unique case (r_state)
        ST_WAIT: begin
          if (bus.move_tick) begin
            if (r_cnt == CNT_LAST) begin
              r_state  <= ST_MOVE;
              r_cnt    <= '0;
              r_moving <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_MOVE: begin
          if (w_hit) begin
            r_state  <= ST_CAUGHT;
            r_caught <= 1'b1;
            r_moving <= 1'b0;
          end else if (bus.move_tick) begin
            r_dir <= w_dir;
            if (w_go) begin
              r_x <= w_x;
              r_y <= w_y;
            end
          end
        end
        ST_CAUGHT: ;
        default: begin
          r_state  <= ST_WAIT;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ghost_pos_x = r_x;
  assign bus.ghost_pos_y = r_y;
  assign bus.ghost_dir   = r_dir;
  assign bus.caught      = r_caught;
  assign bus.moving      = r_moving;

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: directed vector table, corner sequences
// and random traffic against a tile-grid reference model.
module tb_ghost_mover;
  import ghost_pkg::*;

  localparam int W = 640;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ghost_mover_if bus();

  ghost_mover dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         tk;
    bit         en;
    logic [3:0] vm;
    logic [3:0] cd;
    int         ex;
    int         ey;
    logic [3:0] ed;
  } vec_t;

  vec_t tv[$];

  // model: mode 0 = in the house, 1 = roaming, 2 = captured
  int         m_x, m_y, m_mode, m_cnt;
  logic [3:0] m_dir;
  bit         m_caught, m_moving;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x      = 320;
    m_y      = 240;
    m_dir    = 4'b1000;
    m_mode   = 0;
    m_cnt    = 0;
    m_caught = 0;
    m_moving = 0;
  endtask

  task automatic model_edge(input bit tk, en, rs,
                            input logic [3:0] vm, cd,
                            input int px, py);
    int dx, dy;
    bit go;
    if (!en) begin
      m_caught = 0;
      return;
    end
    m_caught = 0;
    if (rs) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == 60) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end
    end else if (m_mode == 1) begin
      dx = m_x - px;
      dy = m_y - py;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < 8 && dy < 8) begin
        m_caught = 1;
        m_mode   = 2;
      end else if (tk) begin
        go = 1;
        if (m_x % 16 == 0 && m_y % 16 == 0) begin
          if ($countones(cd) == 1 && (cd & vm) != 0)
            m_dir = cd;
          else if ((m_dir & vm) != 0)
            m_dir = m_dir;
          else if (vm != 0) begin
            for (int i = 3; i >= 0; i--)
              if (vm[i]) m_dir = 4'(1 << i);
          end else
            go = 0;
        end
        if (go) begin
          case (m_dir)
            4'b0001: m_x = (m_x + 2) % W;
            4'b0010: m_y = m_y - 2;
            4'b0100: m_y = m_y + 2;
            4'b1000: m_x = (m_x - 2 + W) % W;
            default: ;
          endcase
        end
      end
    end
    m_moving = (m_mode == 1);
  endtask

  task automatic cycle(input bit tk, en, rs,
                       input logic [3:0] vm, cd);
    bus.move_tick   = tk;
    bus.enable      = en;
    bus.respawn     = rs;
    bus.valid_moves = vm;
    bus.ctrl_dir    = cd;
    @(posedge clk);
    model_edge(tk, en, rs, vm, cd,
               int'(bus.pacman_pos_x),
               int'(bus.pacman_pos_y));
    @(negedge clk);
    chk("mdl_x", int'(bus.ghost_pos_x), m_x);
    chk("mdl_y", int'(bus.ghost_pos_y), m_y);
    chk("mdl_dir", int'(bus.ghost_dir), int'(m_dir));
    chk("mdl_caught", int'(bus.caught), int'(m_caught));
    chk("mdl_moving", int'(bus.moving), int'(m_moving));
  endtask

  task automatic pac(input int px, py);
    bus.pacman_pos_x = 11'(px);
    bus.pacman_pos_y = 10'(py);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv.push_back('{1'b1, 1'b1, 4'b1010, 4'b0010,
                   320, 238, 4'b0010});
    for (int k = 1; k <= 7; k++)
      tv.push_back('{1'b1, 1'b1, 4'b1111, 4'b0001,
                     320, 238 - 2 * k, 4'b0010});
    tv.push_back('{1'b1, 1'b1, 4'b0000, 4'b0001,
                   320, 224, 4'b0010});
    tv.push_back('{1'b0, 1'b1, 4'b0100, 4'b0000,
                   320, 224, 4'b0010});
    tv.push_back('{1'b1, 1'b0, 4'b0100, 4'b0000,
                   320, 224, 4'b0010});
    tv.push_back('{1'b1, 1'b1, 4'b0100, 4'b0000,
                   320, 226, 4'b0100});
    for (int k = 1; k <= 7; k++)
      tv.push_back('{1'b1, 1'b1, 4'b0000, 4'b1000,
                     320, 226 + 2 * k, 4'b0100});
    tv.push_back('{1'b1, 1'b1, 4'b0011, 4'b1000,
                   322, 240, 4'b0001});
    for (int k = 1; k <= 7; k++)
      tv.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000,
                     322 + 2 * k, 240, 4'b0001});
    tv.push_back('{1'b1, 1'b1, 4'b0101, 4'b1111,
                   338, 240, 4'b0001});

    rst_n           = 1'b0;
    bus.move_tick   = 1'b0;
    bus.enable      = 1'b1;
    bus.respawn     = 1'b0;
    bus.valid_moves = 4'b0000;
    bus.ctrl_dir    = 4'b0000;
    pac(600, 900);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x", int'(bus.ghost_pos_x), 320);
    chk("rst_y", int'(bus.ghost_pos_y), 240);
    chk("rst_dir", int'(bus.ghost_dir), 8);
    chk("rst_moving", int'(bus.moving), 0);
    chk("rst_caught", int'(bus.caught), 0);

    // release delay
    repeat (59) cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("rel59_moving", int'(bus.moving), 0);
    chk("rel59_x", int'(bus.ghost_pos_x), 320);
    chk("rel59_y", int'(bus.ghost_pos_y), 240);
    cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("rel60_moving", int'(bus.moving), 1);

    foreach (tv[i]) begin
      cycle(tv[i].tk, tv[i].en, 1'b0, tv[i].vm, tv[i].cd);
      chk($sformatf("vec%0d_x", i),
          int'(bus.ghost_pos_x), tv[i].ex);
      chk($sformatf("vec%0d_y", i),
          int'(bus.ghost_pos_y), tv[i].ey);
      chk($sformatf("vec%0d_dir", i),
          int'(bus.ghost_dir), int'(tv[i].ed));
      chk($sformatf("vec%0d_moving", i),
          int'(bus.moving), 1);
    end

    // horizontal wrap both ways
    cycle(0, 1, 1, 4'b0000, 4'b0000);
    chk("resp_x", int'(bus.ghost_pos_x), 320);
    chk("resp_moving", int'(bus.moving), 0);
    repeat (60) cycle(1, 1, 0, 4'b0000, 4'b0000);
    repeat (160) cycle(1, 1, 0, 4'b1000, 4'b0000);
    chk("wrapL_pre_x", int'(bus.ghost_pos_x), 0);
    chk("wrapL_pre_y", int'(bus.ghost_pos_y), 240);
    cycle(1, 1, 0, 4'b1000, 4'b0000);
    chk("wrapL_x", int'(bus.ghost_pos_x), 638);
    repeat (7) cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("wrap_624_x", int'(bus.ghost_pos_x), 624);
    cycle(1, 1, 0, 4'b1001, 4'b0001);
    chk("turnR_dir", int'(bus.ghost_dir), 1);
    chk("turnR_x", int'(bus.ghost_pos_x), 626);
    repeat (6) cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("wrapR_pre_x", int'(bus.ghost_pos_x), 638);
    cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("wrapR_x", int'(bus.ghost_pos_x), 0);
    chk("wrapR_dir", int'(bus.ghost_dir), 1);

    // capture at spawn, then respawn together with a tick
    pac(325, 242);
    cycle(0, 1, 1, 4'b0000, 4'b0000);
    repeat (59) cycle(1, 1, 0, 4'b0000, 4'b0000);
    cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("cap_rel_moving", int'(bus.moving), 1);
    chk("cap_rel_caught", int'(bus.caught), 0);
    cycle(0, 1, 0, 4'b1000, 4'b1000);
    chk("cap_caught", int'(bus.caught), 1);
    chk("cap_moving", int'(bus.moving), 0);
    cycle(1, 1, 0, 4'b1000, 4'b1000);
    chk("cap_pulse_end", int'(bus.caught), 0);
    repeat (3) cycle(1, 1, 0, 4'b1000, 4'b1000);
    chk("cap_hold_x", int'(bus.ghost_pos_x), 320);
    chk("cap_hold_y", int'(bus.ghost_pos_y), 240);
    chk("cap_hold_caught", int'(bus.caught), 0);
    pac(600, 900);
    cycle(1, 1, 1, 4'b1000, 4'b1000);
    chk("resp_tick_x", int'(bus.ghost_pos_x), 320);
    chk("resp_tick_dir", int'(bus.ghost_dir), 8);
    chk("resp_tick_moving", int'(bus.moving), 0);

    // enable low freezes the release counter
    repeat (30) cycle(1, 1, 0, 4'b0000, 4'b0000);
    repeat (10) cycle(1, 0, 0, 4'b0000, 4'b0000);
    repeat (29) cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("en_moving59", int'(bus.moving), 0);
    cycle(1, 1, 0, 4'b0000, 4'b0000);
    chk("en_moving60", int'(bus.moving), 1);

    // asynchronous reset between edges
    repeat (5) cycle(1, 1, 0, 4'b1000, 4'b0000);
    chk("arst_pre_x", int'(bus.ghost_pos_x), 310);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(bus.ghost_pos_x), 320);
    chk("arst_y", int'(bus.ghost_pos_y), 240);
    chk("arst_dir", int'(bus.ghost_dir), 8);
    chk("arst_moving", int'(bus.moving), 0);
    chk("arst_caught", int'(bus.caught), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit         tk, en, rs;
      logic [3:0] vm, cd;
      int         px, py;
      if (n % 250 == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          px = m_x + int'($urandom_range(0, 60)) - 30;
          py = m_y + int'($urandom_range(0, 60)) - 30;
          if (px < 0) px = 0;
          if (px > 639) px = 639;
          if (py < 0) py = 0;
          if (py > 479) py = 479;
          pac(px, py);
        end else begin
          pac(int'($urandom_range(0, 639)), 900);
        end
      end
      tk = ($urandom_range(0, 2) == 0);
      en = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 399) == 0);
      vm = 4'($urandom);
      if (m_y < 16) vm[1] = 1'b0;
      if (m_y >= 448) vm[2] = 1'b0;
      if ($urandom_range(0, 3) == 0)
        cd = 4'($urandom);
      else
        cd = 4'b0001 << $urandom_range(0, 3);
      cycle(tk, en, rs, vm, cd);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ghost_mover.md
# ghost_mover

Sequential stage directly downstream of the ghost chase-direction logic: owns one ghost's registered position and heading, samples the chosen direction at tile-aligned decision points, and steps the ghost once per frame tick. Its `ghost_pos_x/y` and `ghost_dir` outputs feed back into the direction logic and the wall detector. It also runs the ghost-house release delay and the pacman-capture check.

## Interface
- `START_X`, 11'd320, spawn x (tile-aligned)
- `START_Y`, 10'd240, spawn y (tile-aligned)
- `START_DIR`, 4'b1000 (LEFT), heading after spawn
- `STEP`, 2, pixels moved per tick; must divide `TILE`
- `TILE`, 16, maze tile size in pixels; power of two
- `RELEASE_TICKS`, 60, ticks spent in WAIT before moving; ≥1
- `SCREEN_W`, 640, horizontal wrap width; multiple of `STEP`
- `COLLIDE_DIST`, 8, capture threshold per axis, pixels
- `clk` in 1: system clock; the only clock
- `rst_n` in 1: reset, asynchronous, active-low
- `move_tick` in 1: one-cycle pulse per frame
- `enable` in 1: low freezes all state, including the release counter
- `respawn` in 1: pulse; returns the ghost to spawn
- `valid_moves` in 4: open directions at the current position, one-hot bits RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000
- `ctrl_dir` in 4: requested direction from the chase logic
- `pacman_pos_x` in 11, `pacman_pos_y` in 10: pacman position
- `ghost_pos_x` out 11, `ghost_pos_y` out 10: registered ghost position
- `ghost_dir` out 4: registered heading, always one-hot
- `caught` out 1: one-cycle pulse on capture
- `moving` out 1: high in the MOVE state

## Operation
- Reset values:
  - position = (`START_X`, `START_Y`)
  - `ghost_dir` = `START_DIR`
  - state = WAIT, release counter = 0
  - `caught` = 0, `moving` = 0
- FSM states are WAIT, MOVE and CAUGHT. When `enable` = 0, no state, register or counter changes, and `caught` = 0.
- WAIT:
  - Each `move_tick` increments the counter.
  - On the tick where counter = `RELEASE_TICKS`-1, the next state is MOVE and the counter clears.
  - Position is held.
- MOVE, on `move_tick`:
  - The ghost is aligned when the low log2(`TILE`) bits of both x and y are zero.
  - When aligned, the heading is chosen in priority order:
    1. `ctrl_dir`, if it is one-hot and `ctrl_dir & valid_moves` ≠ 0.
    2. Otherwise the current `ghost_dir`, if it is in `valid_moves`.
    3. Otherwise the lowest set bit of `valid_moves`.
    4. If `valid_moves` = 0, keep the heading and do not step this tick.
  - When not aligned, keep the heading and ignore `ctrl_dir` and `valid_moves`.
  - Step `STEP` pixels in the heading. Screen y grows downward.
- X wrap-around:
  - Stepping RIGHT from x ≥ `SCREEN_W`-`STEP` gives x = 0.
  - Stepping LEFT from x = 0 gives x = `SCREEN_W`-`STEP`.
- Y never wraps; the maze walls bound it.
- Capture (MOVE only, evaluated every cycle on the registered positions):
  - |Δx| < `COLLIDE_DIST` and |Δy| < `COLLIDE_DIST` → `caught` = 1 for one cycle, next state CAUGHT.
  - Absolute differences use 12-bit unsigned arithmetic; there is no signed wrap.
- CAUGHT: position and heading are held and ticks are ignored until `respawn`.
- `respawn`, in any state: reload the spawn position and `START_DIR`, go to WAIT, clear the counter.
  - `respawn` wins over `move_tick` and over capture in the same cycle.

## Timing
- `ctrl_dir` and `valid_moves` are combinational functions of the current outputs. They are sampled on the same edge that samples `move_tick`. The new position is visible the cycle after the tick.
- `caught` rises one cycle after the position registers first satisfy the capture condition. The state reads CAUGHT in that same cycle.
- WAIT → MOVE takes exactly `RELEASE_TICKS` ticks. `moving` rises the cycle after the final tick.
- A mid-operation `rst_n` assertion forces the reset values immediately, independent of `clk`.
- Reset release is synchronised externally; the block has no reset synchroniser.

## Structure
- The shared package `ghost_pkg` holds:
  - direction constants RIGHT/UP/DOWN/LEFT
  - the FSM state encoding (WAIT, MOVE, CAUGHT)
  - the `TILE_LOG2` helper
- One sub-module, `ghost_collision_check`: combinational absolute-difference compare producing `hit`.
- Heading selection, stepping, wrap, the release counter and the FSM live in `ghost_mover`.

## Test plan
- Reset, then 59 ticks → `moving` = 0, position (320,240). 60th tick → `moving` = 1 on the next cycle.
- MOVE at (320,240), heading LEFT, `ctrl_dir` = UP, `valid_moves` = UP|LEFT, tick → position (320,238), `ghost_dir` = UP. The next 7 ticks, with `ctrl_dir` = RIGHT, stay UP and end at (320,224).
- MOVE at x = 0, heading LEFT, y aligned, `valid_moves` = LEFT, tick → x = 638. At x = 638 heading RIGHT, tick → x = 0.
- Aligned with `valid_moves` = 0 → position unchanged after the tick. With `ctrl_dir` = 4'b0000 and `valid_moves` = DOWN → heading DOWN, y+2.
- Pacman at (325,242), ghost reaches (320,240) → single-cycle `caught`, then ticks ignored. `respawn` asserted together with `move_tick` → spawn position and WAIT.
- `enable` = 0 for 10 ticks in WAIT → counter unchanged. Asynchronous `rst_n` pulse between clock edges in MOVE → reset values immediately.
